// File: rtl/ctrl_data_setup.sv
// ctrl_data_setup: reads a burst of row vectors from the Unified Buffer and
// skews them into the diagonal wavefront fed to the systolic array west edge.
// Lane i is delayed i cycles behind lane 0. Lanes outside the wavefront read 0.

// Per-lane delay: DEPTH register stages for data and valid; output masked to 0
// whenever the lane's valid flag is low.
module ctrl_data_setup_lane #(
  parameter int DATA_BW = 8,
  parameter int DEPTH   = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [DATA_BW-1:0] din,
  input  logic               vin,
  output logic [DATA_BW-1:0] dout,
  output logic               vout
);
  logic [DATA_BW-1:0] d_tail;
  logic               v_tail;

  generate
    if (DEPTH == 0) begin : g_pass
      assign d_tail = din;
      assign v_tail = vin;
    end else begin : g_dly
      logic [DEPTH-1:0][DATA_BW-1:0] dat_pipe;
      logic [DEPTH-1:0]              vld_pipe;

      // Shift data and valid together so they stay aligned
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dat_pipe <= '0;
          vld_pipe <= '0;
        end else begin
          for (int j = DEPTH - 1; j > 0; j--) begin
            dat_pipe[j] <= dat_pipe[j-1];
            vld_pipe[j] <= vld_pipe[j-1];
          end
          dat_pipe[0] <= din;
          vld_pipe[0] <= vin;
        end
      end

      assign d_tail = dat_pipe[DEPTH-1];
      assign v_tail = vld_pipe[DEPTH-1];
    end
  endgenerate

  assign vout = v_tail;
  assign dout = v_tail ? d_tail : '0;
endmodule

module ctrl_data_setup #(
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int ADDRESSSIZE = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDRESSSIZE-1:0]         base_addr,
  input  logic [ADDRESSSIZE-1:0]         num_rows,
  output logic                           ub_read_en,
  output logic [ADDRESSSIZE-1:0]         ub_addr,
  input  logic [DATA_BW*MATRIX_SIZE-1:0] ub_data,
  output logic [DATA_BW*MATRIX_SIZE-1:0] data_out,
  output logic [MATRIX_SIZE-1:0]         data_valid,
  output logic                           busy,
  output logic                           done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  // Drain must cover the UB latency, the capture stage and the longest lane
  localparam int DCW = $clog2(MATRIX_SIZE + 1);

  state_t                 state;
  logic [ADDRESSSIZE-1:0] n_lat;
  logic [ADDRESSSIZE-1:0] rcnt;
  logic [DCW-1:0]         dcnt;

  logic                                      rd_pend;
  logic [MATRIX_SIZE-1:0][DATA_BW-1:0]       stage_data;
  logic                                      stage_vld;
  logic [MATRIX_SIZE-1:0][DATA_BW-1:0]       lane_out;

  // Burst sequencer: issue N reads, wait for the wavefront to exit, pulse done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      n_lat      <= '0;
      rcnt       <= '0;
      dcnt       <= '0;
      ub_read_en <= 1'b0;
      ub_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              n_lat      <= num_rows;
              rcnt       <= '0;
              ub_addr    <= base_addr;
              ub_read_en <= 1'b1;
              busy       <= 1'b1;
              state      <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          if (rcnt == n_lat - ADDRESSSIZE'(1)) begin
            ub_read_en <= 1'b0;
            dcnt       <= '0;
            state      <= DRAIN;
          end else begin
            rcnt    <= rcnt + ADDRESSSIZE'(1);
            ub_addr <= ub_addr + ADDRESSSIZE'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DCW'(MATRIX_SIZE)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track UB read latency and capture returned rows into the common stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend    <= 1'b0;
      stage_vld  <= 1'b0;
      stage_data <= '0;
    end else begin
      rd_pend   <= ub_read_en;
      stage_vld <= rd_pend;
      if (rd_pend) stage_data <= ub_data;
    end
  end

  genvar g;
  generate
    for (g = 0; g < MATRIX_SIZE; g++) begin : g_lane
      ctrl_data_setup_lane #(
        .DATA_BW (DATA_BW),
        .DEPTH   (g)
      ) u_lane (
        .clk  (clk),
        .rstn (rstn),
        .din  (stage_data[g]),
        .vin  (stage_vld),
        .dout (lane_out[g]),
        .vout (data_valid[g])
      );
    end
  endgenerate

  assign data_out = lane_out;
endmodule

// File: tb/tb_ctrl_data_setup.sv
// Directed bench for ctrl_data_setup with a behavioural one-cycle-latency UB.
module tb_ctrl_data_setup;
  localparam int DW = 8;
  localparam int M  = 8;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   num_rows;
  logic            ub_read_en;
  logic [AW-1:0]   ub_addr;
  logic [DW*M-1:0] ub_data;
  logic [DW*M-1:0] data_out;
  logic [M-1:0]    data_valid;
  logic            busy;
  logic            done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] pat_base = 8'h00;
  logic [7:0] pat_off  = 8'h00;

  ctrl_data_setup #(.DATA_BW(DW), .MATRIX_SIZE(M), .ADDRESSSIZE(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .ub_read_en (ub_read_en),
    .ub_addr    (ub_addr),
    .ub_data    (ub_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // UB model: row k (address base+k) holds 16*k+i+off in lane i; garbage when idle
  initial ub_data = '0;
  always @(posedge clk) begin
    logic [7:0] k8;
    k8 = ub_addr - pat_base;
    if (ub_read_en) begin
      for (int i = 0; i < M; i++) ub_data[DW*i +: DW] <= 8'(16 * k8 + i + pat_off);
    end else begin
      ub_data <= '1;
    end
  end

  typedef struct {
    logic         rd;
    logic [7:0]   addr;
    logic         busy;
    logic         done;
    logic [M-1:0] vld;
    logic [63:0]  data;
  } exp_t;

  // Expected outputs in cycle t+c of a burst started in cycle t
  function automatic exp_t expect_at(int c, int n, logic [7:0] base, logic [7:0] off);
    exp_t e;
    int k;
    e.rd   = (c >= 1 && c <= n);
    e.addr = 8'(base + c - 1);
    e.busy = (n > 0 && c >= 1 && c <= n + M + 1);
    e.done = (n == 0) ? (c == 1) : (c == n + M + 2);
    e.vld  = '0;
    e.data = '0;
    for (int i = 0; i < M; i++) begin
      k = c - 3 - i;
      if (k >= 0 && k < n) begin
        e.vld[i]          = 1'b1;
        e.data[8*i +: 8]  = 8'(16 * k + i + off);
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({ub_read_en, ub_addr, data_out, data_valid, busy, done} !== '0)
      $display("FAIL reset_state got en=%b addr=%h data=%h vld=%b busy=%b done=%b exp all 0",
               ub_read_en, ub_addr, data_out, data_valid, busy, done);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int seen_done = 0;
    @(negedge clk); start = 1'b1; base_addr = 8'h20; num_rows = 8'd5;
    pat_base = 8'h20; pat_off = 8'h00;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ub_read_en, busy} !== 2'b11) $display("FAIL rst_mid_pre got en=%b busy=%b exp 11", ub_read_en, busy);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if ({ub_read_en, ub_addr, data_out, data_valid, busy, done} !== '0)
      $display("FAIL rst_mid_zero got en=%b addr=%h data=%h vld=%b busy=%b done=%b exp all 0",
               ub_read_en, ub_addr, data_out, data_valid, busy, done);
    else n_pass++;
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done || busy || ub_read_en || data_valid != '0) seen_done++;
    end
    n_chk++;
    if (seen_done !== 0) $display("FAIL rst_mid_quiet got %0d active cycles exp 0", seen_done);
    else n_pass++;
  endtask

  task automatic test_basic();
    exp_t e;
    @(negedge clk); start = 1'b1; base_addr = 8'h10; num_rows = 8'd3;
    pat_base = 8'h10; pat_off = 8'h00;
    for (int c = 1; c <= 3 + M + 4; c++) begin
      @(negedge clk); start = 1'b0;
      e = expect_at(c, 3, 8'h10, 8'h00);
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {e.rd, e.busy, e.done, e.vld})
        $display("FAIL basic_ctrl c=%0d got %b exp %b", c, {ub_read_en, busy, done, data_valid}, {e.rd, e.busy, e.done, e.vld});
      else n_pass++;
      n_chk++;
      if (data_out !== e.data) $display("FAIL basic_data c=%0d got %h exp %h", c, data_out, e.data);
      else n_pass++;
      if (e.rd) begin
        n_chk++;
        if (ub_addr !== e.addr) $display("FAIL basic_addr c=%0d got %h exp %h", c, ub_addr, e.addr);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    @(negedge clk); start = 1'b1; base_addr = 8'hFE; num_rows = 8'd4;
    pat_base = 8'hFE; pat_off = 8'h03;
    for (int c = 1; c <= 4 + M + 4; c++) begin
      @(negedge clk); start = 1'b0;
      e = expect_at(c, 4, 8'hFE, 8'h03);
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {e.rd, e.busy, e.done, e.vld})
        $display("FAIL wrap_ctrl c=%0d got %b exp %b", c, {ub_read_en, busy, done, data_valid}, {e.rd, e.busy, e.done, e.vld});
      else n_pass++;
      n_chk++;
      if (data_out !== e.data) $display("FAIL wrap_data c=%0d got %h exp %h", c, data_out, e.data);
      else n_pass++;
      if (e.rd) begin
        n_chk++;
        if (ub_addr !== e.addr) $display("FAIL wrap_addr c=%0d got %h exp %h", c, ub_addr, e.addr);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_length();
    @(negedge clk); start = 1'b1; base_addr = 8'h33; num_rows = 8'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0;
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {1'b0, 1'b0, (c == 1), {M{1'b0}}})
        $display("FAIL zero_len c=%0d got en=%b busy=%b done=%b vld=%b exp done=%b only",
                 c, ub_read_en, busy, done, data_valid, (c == 1));
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    @(negedge clk); start = 1'b1; base_addr = 8'h60; num_rows = 8'd2;
    pat_base = 8'h60; pat_off = 8'h01;
    for (int c = 1; c <= 2 + M + 6; c++) begin
      @(negedge clk); start = 1'b0;
      e = expect_at(c, 2, 8'h60, 8'h01);
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {e.rd, e.busy, e.done, e.vld})
        $display("FAIL ign_ctrl c=%0d got %b exp %b", c, {ub_read_en, busy, done, data_valid}, {e.rd, e.busy, e.done, e.vld});
      else n_pass++;
      n_chk++;
      if (data_out !== e.data) $display("FAIL ign_data c=%0d got %h exp %h", c, data_out, e.data);
      else n_pass++;
      // Tempt the FSM during READ and during DONE with a different request
      if (c == 1 || c == 2 + M + 2) begin
        start = 1'b1; base_addr = 8'h99; num_rows = 8'd5;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk); start = 1'b1; base_addr = 8'h40; num_rows = 8'd3;
    pat_base = 8'h40; pat_off = 8'h00;
    for (int c = 1; c <= 3 + M + 3; c++) begin
      @(negedge clk); start = 1'b0;
      e = expect_at(c, 3, 8'h40, 8'h00);
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {e.rd, e.busy, e.done, e.vld})
        $display("FAIL b2b1_ctrl c=%0d got %b exp %b", c, {ub_read_en, busy, done, data_valid}, {e.rd, e.busy, e.done, e.vld});
      else n_pass++;
      n_chk++;
      if (data_out !== e.data) $display("FAIL b2b1_data c=%0d got %h exp %h", c, data_out, e.data);
      else n_pass++;
    end
    // First IDLE cycle after done: launch the second burst
    start = 1'b1; base_addr = 8'h80; num_rows = 8'd2;
    pat_base = 8'h80; pat_off = 8'h08;
    for (int c = 1; c <= 2 + M + 4; c++) begin
      @(negedge clk); start = 1'b0;
      e = expect_at(c, 2, 8'h80, 8'h08);
      n_chk++;
      if ({ub_read_en, busy, done, data_valid} !== {e.rd, e.busy, e.done, e.vld})
        $display("FAIL b2b2_ctrl c=%0d got %b exp %b", c, {ub_read_en, busy, done, data_valid}, {e.rd, e.busy, e.done, e.vld});
      else n_pass++;
      n_chk++;
      if (data_out !== e.data) $display("FAIL b2b2_data c=%0d got %h exp %h", c, data_out, e.data);
      else n_pass++;
      if (e.rd) begin
        n_chk++;
        if (ub_addr !== e.addr) $display("FAIL b2b2_addr c=%0d got %h exp %h", c, ub_addr, e.addr);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_basic();
    test_wrap();
    test_zero_length();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
